aspiradora_scheduler: RTL and testbench



---
 rtl/aspiradora_pkg.sv | 53 +++++
 rtl/aspiradora_scheduler_ms_tick_gen.sv | 34 +++
 rtl/aspiradora_scheduler.sv | 141 ++++++++++++++
 tb/tb_aspiradora_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aspiradora_pkg.sv
// Shared types for the vacuum cleaning-cycle scheduler: FSM state encoding,
// scheduler states and the one-hot command bundle driven into the vacuum FSM.
package aspiradora_pkg;

  typedef enum logic [1:0] {
    POWER_OFF = 2'b00,
    ON        = 2'b01,
    CLEANING  = 2'b10,
    EVADING   = 2'b11
  } fsm_state_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAKE     = 3'd1,
    S_CLEAN    = 3'd2,
    S_EVADE    = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic power_off;
    logic on;
    logic cleaning;
    logic evading;
  } fsm_cmd_t;

  // One-hot command for a scheduler state; IDLE/SHUTDOWN/FAULT all park the FSM.
  function automatic fsm_cmd_t cmd_decode(sched_state_t s);
    fsm_cmd_t c;
    c = '0;
    case (s)
      S_WAKE:  c.on        = 1'b1;
      S_CLEAN: c.cleaning  = 1'b1;
      S_EVADE: c.evading   = 1'b1;
      default: c.power_off = 1'b1;
    endcase
    return c;
  endfunction

  // FSM state the scheduler expects to see back while in state s.
  function automatic fsm_state_t expected_fsm(sched_state_t s);
    fsm_state_t e;
    case (s)
      S_WAKE:  e = ON;
      S_CLEAN: e = CLEANING;
      S_EVADE: e = EVADING;
      default: e = POWER_OFF;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/aspiradora_scheduler_ms_tick_gen.sv
// Millisecond tick generator: free-running divider, one-cycle tick at the
// terminal count. Only rst clears it, so tick phase is independent of the FSM.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic CLK100MHZ,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(TICK_DIV - 1)) cnt_d = '0;
  end

  // tick_q is high exactly while cnt_q sits at the terminal count.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CW'(TICK_DIV - 1));
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/aspiradora_scheduler.sv
// Cleaning-cycle scheduler: turns start/stop/obstacle inputs into one-hot
// commands for the vacuum FSM, times runs on a ms tick and faults on ack timeout.
module aspiradora_scheduler
  import aspiradora_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned CLEAN_MS = 5000,
  parameter int unsigned EVADE_MS = 500,
  parameter int unsigned ACK_MS   = 20
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       obstacle,
  input  logic [1:0] fsm_state,
  output logic       cmd_power_off,
  output logic       cmd_on,
  output logic       cmd_cleaning,
  output logic       cmd_evading,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CLEAN_W = $clog2(CLEAN_MS + 1);
  localparam int unsigned EVADE_W = $clog2(EVADE_MS + 1);
  localparam int unsigned ACK_W   = $clog2(ACK_MS + 1);

  logic tick;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .tick      (tick)
  );

  logic start_s1_q, start_s2_q, start_s3_q;
  logic stop_s1_q, stop_s2_q, stop_s3_q;
  logic obs_s1_q, obs_s2_q;

  // 2-FF synchronizers; stage 3 only remembers stage 2 for edge detection.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      {start_s1_q, start_s2_q, start_s3_q} <= '0;
      {stop_s1_q, stop_s2_q, stop_s3_q}    <= '0;
      {obs_s1_q, obs_s2_q}                 <= '0;
    end else begin
      {start_s1_q, start_s2_q, start_s3_q} <= {start_btn, start_s1_q, start_s2_q};
      {stop_s1_q, stop_s2_q, stop_s3_q}    <= {stop_btn, stop_s1_q, stop_s2_q};
      {obs_s1_q, obs_s2_q}                 <= {obstacle, obs_s1_q};
    end
  end

  logic start_edge_c, stop_edge_c, active_c, has_exp_c;
  assign start_edge_c = start_s2_q & ~start_s3_q;
  assign stop_edge_c  = stop_s2_q & ~stop_s3_q;

  sched_state_t       state_q, state_d;
  logic [CLEAN_W-1:0] clean_q, clean_d;
  logic [EVADE_W-1:0] evade_q, evade_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  fsm_cmd_t           cmd_q;
  logic               busy_q, fault_q;

  assign active_c  = (state_q == S_WAKE) || (state_q == S_CLEAN) || (state_q == S_EVADE);
  assign has_exp_c = active_c || (state_q == S_SHUTDOWN);

  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    evade_d = evade_q;
    ack_d   = ack_q;

    if (tick && state_q == S_CLEAN && clean_q != CLEAN_W'(CLEAN_MS - 1))
      clean_d = clean_q + CLEAN_W'(1);
    if (tick && state_q == S_EVADE && evade_q != EVADE_W'(EVADE_MS - 1))
      evade_d = evade_q + EVADE_W'(1);

    if (active_c && stop_edge_c) begin
      state_d = S_SHUTDOWN;
    end else if (has_exp_c && ack_q == ACK_W'(ACK_MS)) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: if (start_edge_c) begin
          state_d = S_WAKE;
          clean_d = '0;
        end
        S_WAKE: if (fsm_state == ON) state_d = S_CLEAN;
        S_CLEAN: begin
          if (obs_s2_q) begin
            state_d = S_EVADE;
            evade_d = '0;
          end else if (tick && clean_q == CLEAN_W'(CLEAN_MS - 1)) begin
            state_d = S_SHUTDOWN;
          end
        end
        S_EVADE: if (tick && evade_q == EVADE_W'(EVADE_MS - 1)) begin
          if (obs_s2_q) evade_d = '0;
          else          state_d = S_CLEAN;
        end
        S_SHUTDOWN: if (fsm_state == POWER_OFF) state_d = S_IDLE;
        default: ;
      endcase
    end

    // Ack watchdog counts only while the FSM disagrees within a stable state.
    if (state_d != state_q || !has_exp_c || fsm_state == expected_fsm(state_q))
      ack_d = '0;
    else if (tick && ack_q != ACK_W'(ACK_MS))
      ack_d = ack_q + ACK_W'(1);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= S_IDLE;
      clean_q <= '0;
      evade_q <= '0;
      ack_q   <= '0;
      cmd_q   <= cmd_decode(S_IDLE);
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
      evade_q <= evade_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_decode(state_d);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign cmd_power_off = cmd_q.power_off;
  assign cmd_on        = cmd_q.on;
  assign cmd_cleaning  = cmd_q.cleaning;
  assign cmd_evading   = cmd_q.evading;
  assign busy          = busy_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_aspiradora_scheduler.sv
// Directed bench for aspiradora_scheduler with a 1-cycle-lag vacuum FSM model
// and a bench-side ms tick model used to count ticks spent in each state.
module tb_aspiradora_scheduler;

  localparam int TICK_DIV = 4;
  localparam int CLEAN_MS = 10;
  localparam int EVADE_MS = 3;
  localparam int ACK_MS   = 5;

  logic       clk;
  logic       rst, start_btn, stop_btn, obstacle;
  logic [1:0] fsm_state;
  logic       cmd_power_off, cmd_on, cmd_cleaning, cmd_evading, busy, fault;
  logic       fsm_stuck;
  int         mcnt;
  logic       mtick;
  int         vectors = 0;
  int         errors  = 0;

  aspiradora_scheduler #(
    .TICK_DIV (TICK_DIV),
    .CLEAN_MS (CLEAN_MS),
    .EVADE_MS (EVADE_MS),
    .ACK_MS   (ACK_MS)
  ) dut (
    .CLK100MHZ     (clk),
    .rst           (rst),
    .start_btn     (start_btn),
    .stop_btn      (stop_btn),
    .obstacle      (obstacle),
    .fsm_state     (fsm_state),
    .cmd_power_off (cmd_power_off),
    .cmd_on        (cmd_on),
    .cmd_cleaning  (cmd_cleaning),
    .cmd_evading   (cmd_evading),
    .busy          (busy),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vacuum FSM follows the command one cycle later; fsm_stuck pins it off.
  always @(posedge clk) begin
    if (rst || fsm_stuck) fsm_state <= 2'b00;
    else if (cmd_on)       fsm_state <= 2'b01;
    else if (cmd_cleaning) fsm_state <= 2'b10;
    else if (cmd_evading)  fsm_state <= 2'b11;
    else                   fsm_state <= 2'b00;
  end

  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else     mcnt <= (mcnt == TICK_DIV - 1) ? 0 : mcnt + 1;
  end
  assign mtick = (mcnt == TICK_DIV - 1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic launch(output bit ok);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_cleaning) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs from the first CLEAN cycle until busy drops, applying obstacle/stop
  // when the raise_ct-th clean tick is pending and a start pulse at start_ct.
  task automatic run_cycle(input int raise_ct, input int obs_len, input bit do_stop,
                           input int start_ct, output int ct, output int et,
                           output int ent, output int ev_cyc, output bit on_seen,
                           output bit ev_at_drop, output int stop_lat, output bit done);
    int  obs_left, since;
    bit  prev_ev, raised, started;
    ct = 0; et = 0; ent = 0; ev_cyc = 0; on_seen = 0; ev_at_drop = 0;
    stop_lat = -1; done = 0; since = -1; obs_left = 0;
    prev_ev = 0; raised = 0; started = 0;
    for (int n = 0; n < 600; n++) begin
      start_btn = 1'b0;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (cmd_cleaning && mtick) ct++;
      if (cmd_evading && mtick) et++;
      if (cmd_evading) ev_cyc++;
      if (cmd_evading && !prev_ev) ent++;
      prev_ev = cmd_evading;
      if (cmd_on) on_seen = 1'b1;
      if (since >= 0) begin
        since++;
        if (cmd_power_off && stop_lat < 0) stop_lat = since;
      end
      if (obs_left > 0) begin
        obs_left--;
        if (obs_left == 0) begin
          ev_at_drop = cmd_evading;
          obstacle   = 1'b0;
          stop_btn   = 1'b0;
        end
      end
      if (!raised && ct == raise_ct && cmd_cleaning && mtick) begin
        raised   = 1'b1;
        obstacle = 1'b1;
        stop_btn = do_stop;
        obs_left = obs_len;
        since    = do_stop ? 0 : -1;
      end
      if (!started && start_ct >= 0 && ct == start_ct) begin
        started   = 1'b1;
        start_btn = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; obstacle = 1'b0; fsm_stuck = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_power_off, cmd_on, cmd_cleaning, cmd_evading} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_cmd: got %b want 1000", {cmd_power_off, cmd_on, cmd_cleaning, cmd_evading});
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_power_off, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset: got pwr/busy %b want 10", {cmd_power_off, busy});
    end
  endtask

  task automatic test_full_cycle();
    int ct, cyc;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_on !== 1'b0) begin errors++; $display("FAIL start_early: cmd_on got %b want 0", cmd_on); end
    @(negedge clk);
    vectors++;
    if ({cmd_on, busy, cmd_power_off} !== 3'b110) begin
      errors++;
      $display("FAIL start_latency: on/busy/pwr got %b want 110", {cmd_on, busy, cmd_power_off});
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (cmd_cleaning !== 1'b1) begin errors++; $display("FAIL wake_to_clean: got %b want 1", cmd_cleaning); end
    ct = 0; cyc = 0;
    while (cmd_cleaning && cyc < 100) begin
      if (mtick) ct++;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (ct != CLEAN_MS) begin errors++; $display("FAIL clean_ticks: got %0d want %0d", ct, CLEAN_MS); end
    vectors++;
    if (cyc < 37 || cyc > 40) begin errors++; $display("FAIL clean_cycles: got %0d want 37..40", cyc); end
    vectors++;
    if ({cmd_power_off, busy} !== 2'b11) begin
      errors++;
      $display("FAIL shutdown_entry: pwr/busy got %b want 11", {cmd_power_off, busy});
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL shutdown_hold: busy got %b want 1", busy); end
    @(negedge clk);
    vectors++;
    if ({cmd_power_off, busy} !== 2'b10) begin
      errors++;
      $display("FAIL back_to_idle: pwr/busy got %b want 10", {cmd_power_off, busy});
    end
  endtask

  task automatic test_obstacle();
    bit ok, on_seen, evd, done;
    int ct, et, ent, evc, sl;
    launch(ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL obs_launch: got %b want 1", ok); end
    run_cycle(4, 2, 1'b0, -1, ct, et, ent, evc, on_seen, evd, sl, done);
    vectors++;
    if (done !== 1'b1) begin errors++; $display("FAIL obs_done: got %b want 1", done); end
    vectors++;
    if (ct != CLEAN_MS) begin errors++; $display("FAIL obs_clean_ticks: got %0d want %0d", ct, CLEAN_MS); end
    vectors++;
    if (et != EVADE_MS) begin errors++; $display("FAIL obs_evade_ticks: got %0d want %0d", et, EVADE_MS); end
    vectors++;
    if (ent != 1) begin errors++; $display("FAIL obs_evade_entries: got %0d want 1", ent); end
    vectors++;
    if (evc != 10) begin errors++; $display("FAIL obs_evade_cycles: got %0d want 10", evc); end
  endtask

  task automatic test_held_obstacle();
    bit ok, on_seen, evd, done;
    int ct, et, ent, evc, sl;
    launch(ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL held_launch: got %b want 1", ok); end
    run_cycle(2, 32, 1'b0, -1, ct, et, ent, evc, on_seen, evd, sl, done);
    vectors++;
    if (done !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", done); end
    vectors++;
    if (evd !== 1'b1) begin errors++; $display("FAIL held_evading_at_drop: got %b want 1", evd); end
    vectors++;
    if (et != 9) begin errors++; $display("FAIL held_evade_ticks: got %0d want 9", et); end
    vectors++;
    if (ent != 1) begin errors++; $display("FAIL held_evade_entries: got %0d want 1", ent); end
    vectors++;
    if (evc != 34) begin errors++; $display("FAIL held_evade_cycles: got %0d want 34", evc); end
    vectors++;
    if (ct != CLEAN_MS) begin errors++; $display("FAIL held_clean_ticks: got %0d want %0d", ct, CLEAN_MS); end
  endtask

  task automatic test_stop_priority();
    bit ok, on_seen, evd, done;
    int ct, et, ent, evc, sl;
    launch(ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL stop_launch: got %b want 1", ok); end
    run_cycle(3, 3, 1'b1, 1, ct, et, ent, evc, on_seen, evd, sl, done);
    vectors++;
    if (done !== 1'b1) begin errors++; $display("FAIL stop_done: got %b want 1", done); end
    vectors++;
    if (ent != 0) begin errors++; $display("FAIL stop_beats_obstacle: evade entries got %0d want 0", ent); end
    vectors++;
    if (sl != 3) begin errors++; $display("FAIL stop_latency: got %0d want 3", sl); end
    vectors++;
    if (ct != 3) begin errors++; $display("FAIL stop_clean_ticks: got %0d want 3", ct); end
    vectors++;
    if (on_seen !== 1'b0) begin errors++; $display("FAIL start_ignored_in_clean: cmd_on seen %b want 0", on_seen); end
  endtask

  task automatic test_fault();
    int wt;
    bit got;
    fsm_stuck = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    wt = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fault) begin
        got = 1'b1;
        break;
      end
      if (cmd_on && mtick) wt++;
    end
    vectors++;
    if (got !== 1'b1) begin errors++; $display("FAIL fault_reached: got %b want 1", got); end
    vectors++;
    if (wt != ACK_MS) begin errors++; $display("FAIL fault_wake_ticks: got %0d want %0d", wt, ACK_MS); end
    vectors++;
    if ({cmd_power_off, cmd_on, cmd_cleaning, cmd_evading, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL fault_outputs: cmds/busy got %b want 10000",
               {cmd_power_off, cmd_on, cmd_cleaning, cmd_evading, busy});
    end
    fsm_stuck = 1'b0;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if ({fault, cmd_on, cmd_power_off} !== 3'b101) begin
      errors++;
      $display("FAIL fault_sticky: fault/on/pwr got %b want 101", {fault, cmd_on, cmd_power_off});
    end
  endtask

  task automatic test_mid_reset();
    bit ok, on_seen, evd, done;
    int ct, et, ent, evc, sl;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({fault, busy, cmd_power_off} !== 3'b001) begin
      errors++;
      $display("FAIL fault_cleared_by_rst: fault/busy/pwr got %b want 001", {fault, busy, cmd_power_off});
    end
    launch(ok);
    repeat (20) @(negedge clk);
    vectors++;
    if ({ok, cmd_cleaning} !== 2'b11) begin
      errors++;
      $display("FAIL mid_clean: launch/cleaning got %b want 11", {ok, cmd_cleaning});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({cmd_power_off, cmd_cleaning, busy} !== 3'b100) begin
      errors++;
      $display("FAIL mid_rst_idle: pwr/clean/busy got %b want 100", {cmd_power_off, cmd_cleaning, busy});
    end
    launch(ok);
    run_cycle(-1, 0, 1'b0, -1, ct, et, ent, evc, on_seen, evd, sl, done);
    vectors++;
    if ({ok, done} !== 2'b11) begin errors++; $display("FAIL post_rst_cycle: launch/done got %b want 11", {ok, done}); end
    vectors++;
    if (ct != CLEAN_MS) begin errors++; $display("FAIL post_rst_clean_ticks: got %0d want %0d", ct, CLEAN_MS); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_obstacle();
    test_held_obstacle();
    test_stop_priority();
    test_fault();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
